// File: rtl/rr_arb4_enc.sv
// Four-requester round-robin arbiter with registered binary-encoded grant.
// Optional forced-release timeout is compiled in with `define RR_ARB4_TIMEOUT_EN.
module rr_arb4_enc #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       release_i,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] gnt_idx_q;
  logic       gnt_valid_q;

  logic [3:0] req_rot;
  logic [1:0] win_off;
  logic [1:0] win_idx;
  logic       win_found;
  logic       force_to;
  logic       end_of_grant;

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || (1 << CNT_W) <= HOLD_MAX) begin : g_bad_cfg
    $error("rr_arb4_enc: HOLD_MAX must be 1..255 and fit in CNT_W bits");
  end

  // req_rot[k] is the requester k places after the pointer in search order.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = req_i[ptr_q + 2'(gi)];
  end

  always_comb begin
    win_off = 2'd0;
    casez (req_rot)
      4'b???1: win_off = 2'd0;
      4'b??10: win_off = 2'd1;
      4'b?100: win_off = 2'd2;
      4'b1000: win_off = 2'd3;
      default: win_off = 2'd0;
    endcase
  end

  assign win_found = |req_rot;
  assign win_idx   = ptr_q + win_off;

`ifdef RR_ARB4_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // A release or a dropped request at the limit is an ordinary end-of-grant.
  assign force_to  = (state_q == S_GRANT) && (cnt_q == CNT_W'(HOLD_MAX - 1))
                     && !release_i && req_i[gnt_idx_q];
  assign timeout_o = timeout_q;
`else
  assign force_to  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign end_of_grant = release_i || !req_i[gnt_idx_q] || force_to;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB4_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            gnt_idx_q   <= win_idx;
            gnt_valid_q <= 1'b1;
            ptr_q       <= win_idx + 2'd1;
            state_q     <= S_GRANT;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (end_of_grant) begin
`ifdef RR_ARB4_TIMEOUT_EN
            timeout_q <= force_to;
            cnt_q     <= '0;
`endif
            // ptr already points past the owner, so it re-wins only when alone.
            if (win_found) begin
              gnt_idx_q <= win_idx;
              ptr_q     <= win_idx + 2'd1;
            end else begin
              gnt_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else begin
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          state_q     <= S_IDLE;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule
